// File: rtl/ahbgpio_pkg.sv
// Shared types and constants for the two-requester AHB-Lite GPIO arbiter.
package ahbgpio_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned AW      = 32;
    localparam int unsigned DW      = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    // Command captured at grant time; id is the granted requester index.
    typedef struct packed {
        logic          id;
        logic          write;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    // Response returned to the granted requester for one cycle.
    typedef struct packed {
        logic [DW-1:0] rdata;
        logic          perr;
        logic          tmo;
    } rsp_t;

endpackage

// File: rtl/ahbgpio_arbiter_if.sv
// Requester-side command/response bundle and AHB-Lite bus bundle.
interface ahbgpio_req_if;
    import ahbgpio_pkg::*;

    logic [NUM_REQ-1:0]         req_valid;
    logic [NUM_REQ-1:0]         req_ready;
    logic [NUM_REQ-1:0]         req_write;
    logic [NUM_REQ-1:0][AW-1:0] req_addr;
    logic [NUM_REQ-1:0][DW-1:0] req_wdata;
    logic [NUM_REQ-1:0]         rsp_valid;
    logic [NUM_REQ-1:0][DW-1:0] rsp_rdata;
    logic [NUM_REQ-1:0]         rsp_perr;
    logic [NUM_REQ-1:0]         rsp_tmo;

    // Requesters issue commands and consume responses
    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_perr, rsp_tmo
    );

    // Arbiter accepts commands and returns responses
    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_perr, rsp_tmo
    );
endinterface

interface ahbgpio_ahb_if;
    import ahbgpio_pkg::*;

    logic [AW-1:0] HADDR;
    logic [DW-1:0] HWDATA;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic          HSEL;
    logic          HREADY;
    logic [DW-1:0] HRDATA;
    logic          HREADYOUT;
    logic          PARITYERR;

    // Bus master (the arbiter)
    modport master (
        output HADDR, HWDATA, HTRANS, HWRITE, HSEL, HREADY,
        input  HRDATA, HREADYOUT, PARITYERR
    );

    // GPIO slave
    modport slave (
        input  HADDR, HWDATA, HTRANS, HWRITE, HSEL, HREADY,
        output HRDATA, HREADYOUT, PARITYERR
    );
endinterface

// File: rtl/ahbgpio_rr_arb.sv
// Two-way round-robin grant selection with a last-grant register.
module ahbgpio_rr_arb
    import ahbgpio_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic               accept,
    output logic               grant_c
);

    logic last_q;

    // Contention goes to the requester not served last; otherwise the lone requester
    always_comb begin
        grant_c = 1'b0;
        if (&req_valid) begin
            grant_c = ~last_q;
        end else begin
            grant_c = req_valid[1];
        end
    end

    // Reset to 1 so requester 0 wins the first contention
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (accept) begin
            last_q <= grant_c;
        end
    end

endmodule

// File: rtl/ahbgpio_arbiter.sv
// Arbitrates two requesters onto a single AHB-Lite GPIO slave, one transfer at a time.
module ahbgpio_arbiter
    import ahbgpio_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned NREQ    = 2
) (
    input  logic          clk,
    input  logic          HRESET,
    ahbgpio_req_if.slave  req,
    ahbgpio_ahb_if.master ahb
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    state_t          state_q;
    state_t          state_d;
    cmd_t            cmd_q;
    rsp_t            rsp_q;
    logic [CW-1:0]   wait_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic            hsel_q;
    logic [1:0]      htrans_q;
    logic            grant_c;
    logic            accept_c;
    logic            done_c;
    logic            tmo_c;

    ahbgpio_rr_arb u_arb (
        .clk       (clk),
        .rst       (HRESET),
        .req_valid (req.req_valid),
        .accept    (accept_c),
        .grant_c   (grant_c)
    );

    // State register
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; acceptance is held off while reset is asserted
    always_comb begin
        state_d  = state_q;
        accept_c = 1'b0;
        done_c   = 1'b0;
        tmo_c    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if ((|req.req_valid) && !HRESET) begin
                    accept_c = 1'b1;
                    state_d  = ADDR;
                end
            end
            ADDR: begin
                state_d = DATA;
            end
            DATA: begin
                if (ahb.HREADYOUT) begin
                    done_c  = 1'b1;
                    state_d = RESP;
                end else if (wait_q == CW'(TIMEOUT - 1)) begin
                    tmo_c   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Capture the granted command; read commands carry zero write data
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            cmd_q <= '0;
        end else if (accept_c) begin
            cmd_q.id    <= grant_c;
            cmd_q.write <= req.req_write[grant_c];
            cmd_q.addr  <= req.req_addr[grant_c];
            cmd_q.wdata <= req.req_write[grant_c] ? req.req_wdata[grant_c] : '0;
        end
    end

    // Count data-phase wait states, cleared whenever the slave is not stalling
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            wait_q <= '0;
        end else if ((state_q == DATA) && !ahb.HREADYOUT) begin
            wait_q <= wait_q + CW'(1);
        end else begin
            wait_q <= '0;
        end
    end

    // Response payload: sampled on completion, forced on timeout
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            rsp_q <= '0;
        end else if (done_c) begin
            rsp_q.rdata <= cmd_q.write ? '0 : ahb.HRDATA;
            rsp_q.perr  <= ahb.PARITYERR;
            rsp_q.tmo   <= 1'b0;
        end else if (tmo_c) begin
            rsp_q.rdata <= '0;
            rsp_q.perr  <= 1'b0;
            rsp_q.tmo   <= 1'b1;
        end
    end

    // Registered bus control and response strobe, decoded from the next state
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            hsel_q      <= 1'b0;
            htrans_q    <= HTRANS_IDLE;
            rsp_valid_q <= '0;
        end else begin
            hsel_q      <= (state_d == ADDR);
            htrans_q    <= (state_d == ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
            rsp_valid_q <= (state_d == RESP) ? (NREQ'(1) << cmd_q.id) : '0;
        end
    end

    assign req.req_ready = accept_c ? (NREQ'(1) << grant_c) : '0;
    assign req.rsp_valid = rsp_valid_q;
    assign req.rsp_rdata = {NREQ{rsp_q.rdata}};
    assign req.rsp_perr  = {NREQ{rsp_q.perr}};
    assign req.rsp_tmo   = {NREQ{rsp_q.tmo}};

    assign ahb.HADDR  = cmd_q.addr;
    assign ahb.HWRITE = cmd_q.write;
    assign ahb.HWDATA = cmd_q.wdata;
    assign ahb.HSEL   = hsel_q;
    assign ahb.HTRANS = htrans_q;
    assign ahb.HREADY = ahb.HREADYOUT;

endmodule

// File: tb/tb_ahbgpio_arbiter.sv
// Scoreboard bench for ahbgpio_arbiter with a scripted GPIO slave model.
module tb_ahbgpio_arbiter;
    import ahbgpio_pkg::*;

    typedef struct {
        int          id;
        logic [31:0] rdata;
        logic        perr;
        logic        tmo;
    } exp_t;

    typedef struct {
        int   waits;
        logic perr;
    } cfg_t;

    logic clk;
    logic HRESET;

    ahbgpio_req_if rq ();
    ahbgpio_ahb_if ahb ();

    int   checks   = 0;
    int   failures = 0;
    exp_t exp_q[$];
    cfg_t cfg_q[$];

    ahbgpio_arbiter #(
        .TIMEOUT (16),
        .NREQ    (2)
    ) dut (
        .clk    (clk),
        .HRESET (HRESET),
        .req    (rq),
        .ahb    (ahb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] rd_of(input logic [31:0] a);
        return a ^ 32'h5A5A_A5A5;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=no_event required=event", name);
    endtask

    task automatic push_exp(input int id, input logic [31:0] rd, input logic perr, input logic tmo);
        exp_t e;
        e.id = id; e.rdata = rd; e.perr = perr; e.tmo = tmo;
        exp_q.push_back(e);
    endtask

    // Present one command and return just after the accepting edge
    task automatic req_single(input int id, input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        n = 0;
        @(negedge clk);
        rq.req_write[id] = wr;
        rq.req_addr[id]  = addr;
        rq.req_wdata[id] = wdata;
        rq.req_valid[id] = 1'b1;
        #1;
        while (!rq.req_ready[id] && n < 40) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 40) fail_timeout("accept");
        @(posedge clk);
        #1;
        rq.req_valid[id] = 1'b0;
    endtask

    // Count falling edges from acceptance until the response strobe
    task automatic wait_rsp(input int id, output int lat);
        lat = 1;
        @(negedge clk);
        while (!rq.rsp_valid[id] && lat < 60) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Both requesters read continuously; grants must alternate from 'first'
    task automatic rr_grants(input int n, input int first);
        int          e;
        int          t;
        logic [1:0]  ev;
        rq.req_write   = '0;
        rq.req_addr[0] = 32'h0000_0100;
        rq.req_addr[1] = 32'h0000_0204;
        @(negedge clk);
        rq.req_valid = 2'b11;
        for (int k = 0; k < n; k++) begin
            t = 0;
            #1;
            while (rq.req_ready == 2'b00 && t < 40) begin
                @(negedge clk);
                #1;
                t++;
            end
            e  = first ^ (k % 2);
            ev = 2'b01 << e;
            check("rr_grant", 32'(rq.req_ready), 32'(ev));
            push_exp(e, rd_of(e == 0 ? 32'h0000_0100 : 32'h0000_0204), 1'b0, 1'b0);
            @(posedge clk);
            #1;
        end
        rq.req_valid = '0;
        t = 0;
        while (exp_q.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
    endtask

    // GPIO slave: on each address phase, stall for the scripted waits then return data
    initial begin
        cfg_t        c;
        logic [31:0] d;
        ahb.HREADYOUT = 1'b1;
        ahb.HRDATA    = '0;
        ahb.PARITYERR = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (ahb.HSEL && ahb.HTRANS == HTRANS_NONSEQ) begin
                c.waits = 0;
                c.perr  = 1'b0;
                if (cfg_q.size() > 0) c = cfg_q.pop_front();
                d = rd_of(ahb.HADDR);
                @(posedge clk);
                #1;
                repeat (c.waits) begin
                    ahb.HREADYOUT = 1'b0;
                    ahb.HRDATA    = 32'hDEAD_BEEF;
                    ahb.PARITYERR = 1'b0;
                    @(posedge clk);
                    #1;
                end
                ahb.HREADYOUT = 1'b1;
                ahb.HRDATA    = d;
                ahb.PARITYERR = c.perr;
                @(posedge clk);
                #1;
                ahb.HRDATA    = '0;
                ahb.PARITYERR = 1'b0;
            end
        end
    end

    // Monitor: every response strobe pops and checks the oldest expectation
    initial begin
        exp_t       e;
        logic [1:0] ev;
        forever begin
            @(negedge clk);
            if (rq.rsp_valid !== 2'b00) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rsp actual=%b required=00", rq.rsp_valid);
                end else begin
                    e  = exp_q.pop_front();
                    ev = 2'b01 << e.id;
                    check("rsp_valid_onehot", 32'(rq.rsp_valid), 32'(ev));
                    check("rsp_rdata", rq.rsp_rdata[e.id], e.rdata);
                    check("rsp_perr", 32'(rq.rsp_perr[e.id]), 32'(e.perr));
                    check("rsp_tmo", 32'(rq.rsp_tmo[e.id]), 32'(e.tmo));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    // Directed sequence
    initial begin
        int lat;
        HRESET       = 1'b1;
        rq.req_valid = '0;
        rq.req_write = '0;
        rq.req_addr  = '0;
        rq.req_wdata = '0;
        repeat (3) @(negedge clk);
        rq.req_valid = 2'b01;
        #1;
        check("rst_htrans", 32'(ahb.HTRANS), 32'h0);
        check("rst_hsel", 32'(ahb.HSEL), 32'h0);
        check("rst_haddr", ahb.HADDR, 32'h0);
        check("rst_hwdata", ahb.HWDATA, 32'h0);
        check("rst_rsp_valid", 32'(rq.rsp_valid), 32'h0);
        check("rst_req_ready", 32'(rq.req_ready), 32'h0);
        rq.req_valid = '0;
        @(negedge clk);
        HRESET = 1'b0;

        // Zero-wait write from requester 0: phase timing
        push_exp(0, 32'h0, 1'b0, 1'b0);
        req_single(0, 1'b1, 32'h0000_0004, 32'h0001_5A5A);
        @(negedge clk);
        check("addr_hsel", 32'(ahb.HSEL), 32'h1);
        check("addr_htrans", 32'(ahb.HTRANS), 32'h2);
        check("addr_haddr", ahb.HADDR, 32'h0000_0004);
        check("addr_hwrite", 32'(ahb.HWRITE), 32'h1);
        @(negedge clk);
        check("data_htrans", 32'(ahb.HTRANS), 32'h0);
        check("data_hsel", 32'(ahb.HSEL), 32'h0);
        check("data_hwdata", ahb.HWDATA, 32'h0001_5A5A);
        check("data_hready", 32'(ahb.HREADY), 32'h1);
        @(negedge clk);
        check("wr_rsp_at_3", 32'(rq.rsp_valid), 32'h1);

        // Requester 1 arrives during requester 0's response cycle
        push_exp(0, rd_of(32'h0000_0010), 1'b0, 1'b0);
        req_single(0, 1'b0, 32'h0000_0010, 32'h0);
        wait_rsp(0, lat);
        check("rd_latency", 32'(lat), 32'd3);
        rq.req_write[1] = 1'b0;
        rq.req_addr[1]  = 32'h0000_0020;
        rq.req_valid[1] = 1'b1;
        #1;
        check("resp_ready_low", 32'(rq.req_ready), 32'h0);
        push_exp(1, rd_of(32'h0000_0020), 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("idle_ready1", 32'(rq.req_ready), 32'h2);
        @(posedge clk);
        #1;
        rq.req_valid[1] = 1'b0;
        wait_rsp(1, lat);
        check("req1_latency", 32'(lat), 32'd3);

        // Continuous contention alternates starting with requester 0
        rr_grants(4, 0);

        // Three wait states with parity error at completion
        cfg_q.push_back('{3, 1'b1});
        push_exp(1, rd_of(32'h0000_0030), 1'b1, 1'b0);
        req_single(1, 1'b0, 32'h0000_0030, 32'h0);
        wait_rsp(1, lat);
        check("wait3_latency", 32'(lat), 32'd6);

        // Fifteen wait states completes normally
        cfg_q.push_back('{15, 1'b0});
        push_exp(0, rd_of(32'h0000_0040), 1'b0, 1'b0);
        req_single(0, 1'b0, 32'h0000_0040, 32'h0);
        wait_rsp(0, lat);
        check("wait15_latency", 32'(lat), 32'd18);

        // Sixteen wait states times out
        cfg_q.push_back('{16, 1'b1});
        push_exp(1, 32'h0, 1'b0, 1'b1);
        req_single(1, 1'b0, 32'h0000_0050, 32'h0);
        wait_rsp(1, lat);
        check("tmo_latency", 32'(lat), 32'd18);
        @(negedge clk);
        check("post_tmo_htrans", 32'(ahb.HTRANS), 32'h0);
        repeat (3) @(negedge clk);

        // Reset during data phase aborts silently
        cfg_q.push_back('{3, 1'b0});
        req_single(0, 1'b0, 32'h0000_0060, 32'h0);
        @(negedge clk);
        @(negedge clk);
        #2;
        HRESET = 1'b1;
        #1;
        check("abort_haddr", ahb.HADDR, 32'h0);
        check("abort_hsel", 32'(ahb.HSEL), 32'h0);
        check("abort_htrans", 32'(ahb.HTRANS), 32'h0);
        check("abort_hwrite", 32'(ahb.HWRITE), 32'h0);
        check("abort_rsp_valid", 32'(rq.rsp_valid), 32'h0);
        repeat (3) @(negedge clk);
        HRESET = 1'b0;
        repeat (4) @(negedge clk);

        // Last grant was 0 before reset; reset must restore requester 0 priority
        rr_grants(2, 0);

        lat = 0;
        while (exp_q.size() != 0 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        repeat (3) @(negedge clk);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ahbgpio_arbiter.md
AHBGPIO_ARBITER -- requirements
Module: ahbgpio_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, max HREADYOUT-low data-phase cycles before abort.
REQ-002 SHALL have parameter NREQ, fixed at 2, number of requesters.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port HRESET  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports req_valid[i]  input  1  and req_ready[i]  output  1  per-requester command handshake.
REQ-006 SHALL have ports req_write[i]  input  1, req_addr[i]  input  32, req_wdata[i]  input  32  command payload.
REQ-007 SHALL have ports rsp_valid[i]  output  1, rsp_rdata[i]  output  32, rsp_perr[i]  output  1, rsp_tmo[i]  output  1  one-cycle response.
REQ-008 SHALL have ports HADDR  output  32, HWDATA  output  32, HTRANS  output  2, HWRITE  output  1, HSEL  output  1, HREADY  output  1  AHB-Lite master to GPIO slave.
REQ-009 SHALL have ports HRDATA  input  32, HREADYOUT  input  1, PARITYERR  input  1  GPIO slave returns.

Function
REQ-010 SHALL be FSM IDLE -> ADDR -> DATA -> RESP -> IDLE; one transfer outstanding.
REQ-011 IDLE: any req_valid -> grant, assert req_ready[grant] that cycle, capture payload, go ADDR next cycle.
REQ-012 Arbitration SHALL be round-robin: both valid -> grant requester not granted last; single valid -> that one; after reset requester 0 has priority.
REQ-013 req_ready SHALL be 0 outside IDLE and 0 for the non-granted requester.
REQ-014 ADDR (exactly 1 cycle): HSEL=1, HTRANS=NONSEQ (2'b10), HADDR/HWRITE = captured; then DATA.
REQ-015 DATA: HTRANS=IDLE (2'b00), HSEL=0, HWDATA = captured wdata (writes); stay while HREADYOUT=0.
REQ-016 DATA with HREADYOUT=1: sample HRDATA (reads only, else 0) and PARITYERR into response regs; go RESP.
REQ-017 Wait counter SHALL count DATA cycles with HREADYOUT=0; reaching TIMEOUT -> go RESP with rsp_tmo=1, rsp_rdata=0, rsp_perr=0.
REQ-018 RESP (1 cycle): rsp_valid[grant]=1 with rdata/perr/tmo; all other rsp_valid=0; then IDLE.
REQ-019 Minimum latency SHALL be 3 cycles from accepted req to rsp_valid (zero wait states); new grant earliest the cycle after RESP.
REQ-020 HREADY output SHALL equal HREADYOUT (single-slave loopback); HTRANS=IDLE, HSEL=0 in IDLE/RESP.
REQ-021 req_valid changes after acceptance SHALL have no effect on the in-flight transfer.
REQ-022 Requester asserting req_valid in RESP SHALL be considered in the following IDLE cycle under REQ-012.

Reset
REQ-023 HRESET SHALL force IDLE, wait counter 0, last-grant = 1 (so requester 0 wins), all outputs 0, HTRANS=2'b00.
REQ-024 HRESET mid-transfer SHALL abort silently: no rsp_valid emitted for the aborted command.
REQ-025 First transfer after reset release SHALL start no earlier than the first rising edge with HRESET=0.

Structure
REQ-026 Package ahbgpio_pkg SHALL hold state enum (IDLE/ADDR/DATA/RESP), HTRANS constants (HTRANS_IDLE, HTRANS_NONSEQ), and command/response structs.
REQ-027 Sub-module ahbgpio_rr_arb SHALL implement the 2-way round-robin grant with last-grant register.
REQ-028 Main module SHALL contain FSM, capture registers, wait counter and response registers.

Verification
REQ-029 Req0 write addr 0x0000_0004 data 0x0001_5A5A, HREADYOUT=1 -> ADDR with NONSEQ at cycle+1, HWDATA=0x0001_5A5A at cycle+2, rsp_valid[0] at cycle+3, perr=0, tmo=0.
REQ-030 Req0 and req1 reads both valid continuously -> grants 0,1,0,1; each rsp_rdata matches HRDATA driven in its data phase.
REQ-031 Read with HREADYOUT low 3 cycles, PARITYERR=1 at completion -> rsp_valid 6 cycles after accept, rsp_perr=1, tmo=0.
REQ-032 HREADYOUT held low -> after 16 wait cycles rsp_tmo=1, rsp_rdata=0, FSM back to IDLE.
REQ-033 HRESET asserted in DATA -> outputs 0 asynchronously, no rsp_valid; after release req0 wins a simultaneous request.
REQ-034 Req1 asserts req_valid during req0's RESP -> req1 granted next IDLE cycle, req_ready[1]=1.
